axi_traffic_initiator: RTL and testbench

AXI4 master that drives deterministic write-then-read-back burst traffic into a memory-side subordinate, such as the memory island or the golden-model comparator wrapper. It sits on the initiator end of the unit-test AXI port. It issues one burst at a time with a single outstanding transaction, checks every response and every read beat against the written pattern, and reports a saturating error count. This is the stimulus and self-check side of the memory-island benches.

---
 rtl/axi_traffic_initiator.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi_traffic_initiator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_traffic_initiator : AXI4 write-then-read-back burst traffic + checker   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

package axi_traffic_initiator_pkg;
   localparam int unsigned AddrWidth = 48;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned IdWidth   = 6;
   localparam int unsigned UserWidth = 2;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [5:0]           atop;
      logic [UserWidth-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
      logic                   last;
      logic [UserWidth-1:0]   user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;
endpackage

module axi_traffic_initiator #(
   parameter type                 axi_req_t = axi_traffic_initiator_pkg::axi_req_t,
   parameter type                 axi_rsp_t = axi_traffic_initiator_pkg::axi_rsp_t,
   parameter int unsigned         AddrWidth = 48,
   parameter int unsigned         DataWidth = 64,
   parameter int unsigned         IdWidth   = 6,
   parameter int unsigned         UserWidth = 2,
   parameter int unsigned         NumBeats  = 8,
   parameter int unsigned         NumBursts = 16,
   parameter logic [AddrWidth-1:0] BaseAddr = '0,
   parameter logic [31:0]         Seed      = 32'hA5A5_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output axi_req_t    axi_req_o,
   input  axi_rsp_t    axi_rsp_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] err_cnt_o
);

   localparam int unsigned   BytesPerBeat = DataWidth / 8;
   localparam int unsigned   SizeVal      = $clog2(BytesPerBeat);
   localparam int unsigned   BurstBytes   = NumBeats * BytesPerBeat;
   localparam int unsigned   BurstW       = $clog2(NumBursts + 1);
   localparam int unsigned   Copies       = DataWidth / 32;
   localparam logic [7:0]    LastBeat     = 8'(NumBeats - 1);
   localparam logic [BurstW-1:0] LastBurst = BurstW'(NumBursts - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5,
      S_DONE = 3'd6
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           beat_q, beat_d;
   logic [BurstW-1:0]    burst_q, burst_d;
   logic [AddrWidth-1:0] addr_q, addr_d;   // base address of the current burst
   logic [AddrWidth-1:0] baddr_q, baddr_d; // address of the current beat
   logic [15:0]          err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   axi_req_t             req_q, req_d;
   logic                 err_inc;
   logic                 err_clr;

   function automatic logic [DataWidth-1:0] beat_data(input logic [31:0] a);
      return {Copies{a ^ Seed}};
   endfunction

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      addr_d  = addr_q;
      baddr_d = baddr_q;
      err_inc = 1'b0;
      err_clr = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_AW;
               beat_d  = '0;
               burst_d = '0;
               addr_d  = BaseAddr;
               baddr_d = BaseAddr;
               err_clr = 1'b1;
            end
         end
         S_AW: begin
            if (axi_rsp_i.aw_ready) state_d = S_W;
         end
         S_W: begin
            if (axi_rsp_i.w_ready) begin
               if (beat_q == LastBeat) begin
                  beat_d  = '0;
                  baddr_d = addr_q;
                  state_d = S_B;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  baddr_d = baddr_q + AddrWidth'(BytesPerBeat);
               end
            end
         end
         S_B: begin
            if (axi_rsp_i.b_valid) begin
               state_d = S_AR;
               err_inc = (axi_rsp_i.b.resp != 2'b00) || (axi_rsp_i.b.id != '0);
            end
         end
         S_AR: begin
            if (axi_rsp_i.ar_ready) state_d = S_R;
         end
         S_R: begin
            if (axi_rsp_i.r_valid) begin
               err_inc = (axi_rsp_i.r.data != beat_data(baddr_q[31:0]))
                      || (axi_rsp_i.r.resp != 2'b00)
                      || (axi_rsp_i.r.id != '0)
                      || (axi_rsp_i.r.last != (beat_q == LastBeat));
               // An early rlast ends the burst just like the final counted beat.
               if (axi_rsp_i.r.last || (beat_q == LastBeat)) begin
                  beat_d  = '0;
                  burst_d = burst_q + BurstW'(1);
                  if (burst_q == LastBurst) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_AW;
                     addr_d  = addr_q + AddrWidth'(BurstBytes);
                     baddr_d = addr_q + AddrWidth'(BurstBytes);
                  end
               end else begin
                  beat_d  = beat_q + 8'd1;
                  baddr_d = baddr_q + AddrWidth'(BytesPerBeat);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if (err_clr) begin
         err_d = '0;
      end else if (err_inc && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end else begin
         err_d = err_q;
      end
   end

   assign busy_d = (state_d == S_AW) || (state_d == S_W) || (state_d == S_B)
                || (state_d == S_AR) || (state_d == S_R);
   assign done_d = (state_d == S_DONE);

   // Request is built from next-state values so every output comes straight from a flop.
   always_comb begin
      req_d = '0;
      unique case (state_d)
         S_AW: begin
            req_d.aw_valid = 1'b1;
            req_d.aw.addr  = addr_d;
            req_d.aw.len   = LastBeat;
            req_d.aw.size  = 3'(SizeVal);
            req_d.aw.burst = 2'b01;
         end
         S_W: begin
            req_d.w_valid = 1'b1;
            req_d.w.data  = beat_data(baddr_d[31:0]);
            req_d.w.strb  = '1;
            req_d.w.last  = (beat_d == LastBeat);
         end
         S_B:  req_d.b_ready = 1'b1;
         S_AR: begin
            req_d.ar_valid = 1'b1;
            req_d.ar.addr  = addr_d;
            req_d.ar.len   = LastBeat;
            req_d.ar.size  = 3'(SizeVal);
            req_d.ar.burst = 2'b01;
         end
         S_R:  req_d.r_ready = 1'b1;
         default: req_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         burst_q <= '0;
         addr_q  <= BaseAddr;
         baddr_q <= BaseAddr;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         baddr_q <= baddr_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         req_q   <= req_d;
      end
   end

   logic w_unused;
   assign w_unused = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

   assign axi_req_o = req_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_cnt_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_traffic_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_traffic_initiator : bench with behavioural AXI memory subordinate    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_axi_traffic_initiator;
   import axi_traffic_initiator_pkg::*;

   localparam int          NB     = 8;
   localparam int          NBURST = 4;
   localparam logic [47:0] BASE   = 48'h1000;
   localparam logic [31:0] SEED   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   axi_req_t    req;
   axi_rsp_t    rsp;
   logic        busy;
   logic        done;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   axi_traffic_initiator #(
      .axi_req_t (axi_req_t),
      .axi_rsp_t (axi_rsp_t),
      .AddrWidth (48),
      .DataWidth (64),
      .IdWidth   (6),
      .UserWidth (2),
      .NumBeats  (NB),
      .NumBursts (NBURST),
      .BaseAddr  (BASE),
      .Seed      (SEED)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .axi_req_o (req),
      .axi_rsp_i (rsp),
      .busy_o    (busy),
      .done_o    (done),
      .err_cnt_o (err_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference pattern straight from the data rule: Seed-xored low address word, replicated.
   function automatic logic [63:0] exp_data(input logic [47:0] a);
      logic [31:0] w;
      w = a[31:0] ^ SEED;
      return {w, w};
   endfunction

   // Subordinate knobs and state
   bit          bp_en = 0;
   int          corrupt_burst = -1;
   int          slverr_burst = -1;
   int          early_burst = -1;
   int          aw_cnt = 0, ar_cnt = 0, wbeat = 0, rbeat = 0, r_burst = 0;
   bit          b_pend = 0, r_act = 0;
   bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
   logic [47:0] cur_waddr, cur_raddr;
   aw_chan_t    prev_aw;
   w_chan_t     prev_w;
   ar_chan_t    prev_ar;
   logic [63:0] mem [logic [47:0]];
   logic [47:0] aw_log[$];

   // Memory subordinate: all decisions at the falling edge; handshakes it predicts
   // complete at the following rising edge.
   initial begin
      logic [47:0] a;
      logic [63:0] rd;
      rsp = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rsp = '0;
            b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
         end else begin
            if (aw_pend) check("aw_stable", {62'd0, req.aw_valid, req.aw == prev_aw}, 64'd3);
            if (w_pend)  check("w_stable",  {62'd0, req.w_valid,  req.w == prev_w},   64'd3);
            if (ar_pend) check("ar_stable", {62'd0, req.ar_valid, req.ar == prev_ar}, 64'd3);
            check("one_channel",
                  64'($countones({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}) <= 1),
                  64'd1);

            rsp.aw_ready = bp_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            rsp.w_ready  = bp_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            rsp.ar_ready = bp_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            rsp.b_valid  = b_pend && (!bp_en || ($urandom_range(0, 1) == 0));
            rsp.b        = '0;
            if ((aw_cnt - 1) == slverr_burst) rsp.b.resp = 2'b10;
            rsp.r_valid  = r_act && (!bp_en || ($urandom_range(0, 1) == 0));
            rsp.r        = '0;
            if (r_act) begin
               a  = cur_raddr + 48'(rbeat * 8);
               rd = mem.exists(a) ? mem[a] : 64'd0;
               if (r_burst == corrupt_burst && rbeat == 3) rd[0] = ~rd[0];
               rsp.r.data = rd;
               rsp.r.last = (rbeat == NB - 1) || (r_burst == early_burst && rbeat == 6);
            end

            if (req.aw_valid && rsp.aw_ready) begin
               check("aw_addr", 64'(req.aw.addr), 64'(BASE + 48'(aw_cnt * 64)));
               check("aw_len", 64'(req.aw.len), 64'd7);
               check("aw_size", 64'(req.aw.size), 64'd3);
               check("aw_burst", 64'(req.aw.burst), 64'd1);
               check("aw_id", 64'(req.aw.id), 64'd0);
               check("aw_misc", 64'({req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos,
                                     req.aw.region, req.aw.atop, req.aw.user}), 64'd0);
               aw_log.push_back(req.aw.addr);
               cur_waddr = req.aw.addr;
               wbeat = 0;
               aw_cnt++;
            end
            if (req.w_valid && rsp.w_ready) begin
               a = cur_waddr + 48'(wbeat * 8);
               check("w_data", req.w.data, exp_data(a));
               check("w_strb", 64'(req.w.strb), 64'hFF);
               check("w_last", 64'(req.w.last), 64'(wbeat == NB - 1));
               mem[a] = req.w.data;
               wbeat++;
               if (req.w.last) b_pend = 1;
            end
            if (req.b_ready && rsp.b_valid) b_pend = 0;
            if (req.ar_valid && rsp.ar_ready) begin
               check("ar_addr", 64'(req.ar.addr), 64'(BASE + 48'(ar_cnt * 64)));
               check("ar_len", 64'(req.ar.len), 64'd7);
               check("ar_size_burst_id", 64'({req.ar.size, req.ar.burst, req.ar.id}), 64'({3'd3, 2'd1, 6'd0}));
               cur_raddr = req.ar.addr;
               rbeat = 0;
               r_act = 1;
               r_burst = ar_cnt;
               ar_cnt++;
            end else if (req.r_ready && rsp.r_valid) begin
               if (rsp.r.last) r_act = 0;
               rbeat++;
            end

            aw_pend = req.aw_valid && !rsp.aw_ready;
            w_pend  = req.w_valid  && !rsp.w_ready;
            ar_pend = req.ar_valid && !rsp.ar_ready;
            prev_aw = req.aw;
            prev_w  = req.w;
            prev_ar = req.ar;
         end
      end
   end

   task automatic start_run();
      aw_cnt = 0;
      ar_cnt = 0;
      aw_log.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("done_cleared", 64'(done), 64'd0);
      check("err_cleared", 64'(err_cnt), 64'd0);
      check("aw_valid_after_start", 64'(req.aw_valid), 64'd1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_reached", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
   endtask

   task automatic check_aw_seq();
      check("aw_count", 64'(aw_log.size()), 64'(NBURST));
      foreach (aw_log[k]) check("aw_seq", 64'(aw_log[k]), 64'(BASE + 48'(k * 64)));
   endtask

   typedef struct {
      bit bp;
      int corrupt_burst;
      int slverr_burst;
      int early_burst;
      int exp_err;
      int max_cyc;
   } vec_t;

   vec_t vecs[4];
   int   cyc;
   int   n;

   initial begin
      vecs[0] = '{0, -1, -1, -1, 0, 80};
      vecs[1] = '{1, -1, -1, -1, 0, 3000};
      vecs[2] = '{0,  1, -1, -1, 1, 80};
      vecs[3] = '{1, -1,  2,  3, 2, 3000};

      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valids", 64'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 64'd0);
      check("rst_aw_addr", 64'(req.aw.addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err_cnt), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         bp_en = vecs[i].bp;
         corrupt_burst = vecs[i].corrupt_burst;
         slverr_burst = vecs[i].slverr_burst;
         early_burst = vecs[i].early_burst;
         start_run();
         wait_done(cyc);
         check("run_cycles_bound", 64'(cyc <= vecs[i].max_cyc), 64'd1);
         check("run_err_cnt", 64'(err_cnt), 64'(vecs[i].exp_err));
         check_aw_seq();
         repeat (3) @(negedge clk);
         check("done_sticky", 64'(done), 64'd1);
      end

      // Reset while W beat 4 of burst 0 is on the bus
      bp_en = 0; corrupt_burst = -1; slverr_burst = -1; early_burst = -1;
      start_run();
      n = 0;
      while (!(req.w_valid && req.w.data == exp_data(BASE + 48'h20)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("w_beat4_reached", 64'(n < 100), 64'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valids", 64'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_err", 64'(err_cnt), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_run();
      check("restart_aw_addr", 64'(req.aw.addr), 64'(BASE));
      wait_done(cyc);
      check("restart_err", 64'(err_cnt), 64'd0);
      check_aw_seq();

      // start while busy is ignored; start in DONE reruns and clears counters
      corrupt_burst = 1;
      start_run();
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_ignores_start", 64'(busy), 64'd1);
      wait_done(cyc);
      check("busy_run_err", 64'(err_cnt), 64'd1);
      check_aw_seq();
      corrupt_burst = -1;
      start_run();
      wait_done(cyc);
      check("rerun_err", 64'(err_cnt), 64'd0);
      check_aw_seq();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
